timer_ctrl: RTL and testbench

Memory-mapped controller for the free-running timer peripheral. It adds a programmable prescaler, compare-match detection, periodic/one-shot sequencing, a sticky match flag and an interrupt line. It sits on the data-memory peripheral bus alongside the other peripherals, with word-addressed registers selected by A.

---
 rtl/timer_ctrl.sv | 93 +++++++++
 tb/tb_timer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Memory-mapped timer controller: prescaler, compare match, periodic/one-shot
// sequencing, sticky W1C match flag and interrupt.
module timer_ctrl #(
  parameter logic [31:0] PRESCALE_RST = 32'd50_000,
  parameter logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        en, oneshot, ie, match;
  logic [31:0] prescale, count, compare, psc;

  logic wr_ctrl, wr_pre, wr_cnt, wr_cmp, wr_stat;
  logic tick, tick_eff, hit;

  assign wr_ctrl = WE && (A == 3'd0);
  assign wr_pre  = WE && (A == 3'd1);
  assign wr_cnt  = WE && (A == 3'd2);
  assign wr_cmp  = WE && (A == 3'd3);
  assign wr_stat = WE && (A == 3'd4);

  // A COUNT write or an EN-clearing CTRL write pre-empts the tick; the
  // compare uses the COMPARE value held before any same-cycle write.
  assign tick     = (state == RUN) && en && (psc == prescale);
  assign tick_eff = tick && !wr_cnt && !(wr_ctrl && !WD[0]);
  assign hit      = tick_eff && (count == compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en       <= 1'b0;
      oneshot  <= 1'b0;
      ie       <= 1'b0;
      match    <= 1'b0;
      prescale <= PRESCALE_RST;
      count    <= '0;
      compare  <= COMPARE_RST;
      psc      <= '0;
    end else begin
      if (wr_ctrl) {ie, oneshot, en} <= WD[2:0];
      if (wr_pre)  prescale <= WD;
      if (wr_cmp)  compare  <= WD;

      if (wr_cnt)        count <= WD;
      else if (tick_eff) count <= hit ? '0 : count + 32'd1;

      // Set beats a same-cycle W1C
      if (wr_stat && WD[0]) match <= 1'b0;
      if (hit)              match <= 1'b1;

      // psc sits at 0 outside RUN, so every RUN entry starts a fresh period
      if (wr_pre || state != RUN) psc <= '0;
      else if (psc == prescale)   psc <= '0;
      else                        psc <= psc + 32'd1;

      case (state)
        IDLE, DONE: if (en) state <= RUN;
        RUN: begin
          if (!en) state <= IDLE;
          else if (hit && oneshot) begin
            state <= DONE;
            en    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      3'd0: RD = {29'd0, ie, oneshot, en};
      3'd1: RD = prescale;
      3'd2: RD = count;
      3'd3: RD = compare;
      3'd4: RD = {29'd0, state == DONE, state == RUN, match};
      default: RD = '0;
    endcase
  end

  assign irq = match & ie;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: stimulus queues expected RD/irq per read
// cycle, a monitor pops and compares on the falling edge.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  A   = '0;
  logic [31:0] WD  = '0;
  logic        WE  = 1'b0;
  logic [31:0] RD;
  logic        irq;
  logic        chk_v = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];

  timer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WD  (WD),
    .WE  (WE),
    .RD  (RD),
    .irq (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_v) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (RD !== e.rd || irq !== e.irq) begin
          n_fail++;
          $display("FAIL %s: got RD=%h irq=%b, expected RD=%h irq=%b",
                   e.name, RD, irq, e.rd, e.irq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic chk(input logic [2:0] a, input logic [31:0] rd, input logic ir, input string nm);
    exp_t e;
    e.rd = rd; e.irq = ir; e.name = nm;
    A = a;
    sb.push_back(e);
    chk_v = 1'b1;
    step();
    chk_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] per_cnt [13];
    logic [31:0] os_cnt  [7];
    logic [31:0] wrap_cnt[6];
    per_cnt  = '{0,0,0,0,0,1,1,1,1,2,2,2,2};
    os_cnt   = '{0,0,1,2,3,4,5};
    wrap_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 0};

    // 1. reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk(3'd1, 32'd50000, 1'b0, "rst_prescale");
    chk(3'd0, 32'd0, 1'b0, "rst_ctrl");
    chk(3'd2, 32'd0, 1'b0, "rst_count");
    chk(3'd3, 32'hFFFF_FFFF, 1'b0, "rst_compare");
    chk(3'd4, 32'd0, 1'b0, "rst_status");

    // 2. periodic, PRESCALE=3 COMPARE=2 EN|IE
    wr(3'd1, 32'd3);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd5);
    for (int k = 0; k < 13; k++) chk(3'd2, per_cnt[k], 1'b0, "per_count");
    chk(3'd4, 32'd3, 1'b1, "per_match_irq");
    wr(3'd4, 32'd1);
    chk(3'd4, 32'd2, 1'b0, "per_w1c");
    chk(3'd2, 32'd0, 1'b0, "per_cont0");
    chk(3'd2, 32'd1, 1'b0, "per_cont1");
    wr(3'd0, 32'd0);
    step(); step();

    // 3. one-shot, PRESCALE=0 COMPARE=5
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd5);
    wr(3'd0, 32'd3);
    for (int k = 0; k < 7; k++) chk(3'd2, os_cnt[k], 1'b0, "os_count");
    chk(3'd2, 32'd0, 1'b0, "os_wrap0");
    chk(3'd0, 32'd2, 1'b0, "os_ctrl");
    chk(3'd4, 32'd5, 1'b0, "os_status_done");
    chk(3'd2, 32'd0, 1'b0, "os_frozen");
    wr(3'd0, 32'd3);
    chk(3'd4, 32'd5, 1'b0, "os_still_done");
    chk(3'd4, 32'd3, 1'b0, "os_rerun");
    chk(3'd2, 32'd1, 1'b0, "os_rerun_count");
    wr(3'd0, 32'd0);
    chk(3'd2, 32'd2, 1'b0, "ctrl_off_vs_tick");
    chk(3'd2, 32'd2, 1'b0, "idle_frozen");
    chk(3'd4, 32'd1, 1'b0, "idle_status");
    wr(3'd4, 32'd1);
    chk(3'd4, 32'd0, 1'b0, "idle_w1c");

    // 4. collisions, PRESCALE=0 so every RUN cycle ticks
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd100);
    wr(3'd0, 32'd1);
    step(); step();
    wr(3'd2, 32'h40);
    chk(3'd2, 32'h40, 1'b0, "count_wr_vs_tick");
    chk(3'd2, 32'h41, 1'b0, "count_after_wr");
    wr(3'd3, 32'h44);
    chk(3'd2, 32'h43, 1'b0, "count_pre_match");
    wr(3'd4, 32'd1);
    chk(3'd4, 32'd3, 1'b0, "w1c_vs_match");
    chk(3'd2, 32'd1, 1'b0, "count_post_match");
    wr(3'd0, 32'd0);
    step();
    wr(3'd4, 32'd1);

    // 5. wrap through 0xFFFFFFFF
    wr(3'd1, 32'd0);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd1);
    for (int k = 0; k < 6; k++) chk(3'd2, wrap_cnt[k], 1'b0, "wrap_count");
    chk(3'd4, 32'd3, 1'b0, "wrap_match");
    wr(3'd0, 32'd0);
    step();
    wr(3'd4, 32'd1);

    // 6. reset mid-run at COUNT=7
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd100);
    wr(3'd0, 32'd5);
    for (int k = 0; k < 8; k++) chk(3'd2, (k == 0) ? 32'd0 : 32'(k - 1), 1'b0, "run_count");
    rst = 1'b1;
    chk(3'd2, 32'd7, 1'b0, "pre_rst_count");
    rst = 1'b0;
    chk(3'd2, 32'd0, 1'b0, "post_rst_count");
    chk(3'd0, 32'd0, 1'b0, "post_rst_ctrl");
    chk(3'd4, 32'd0, 1'b0, "post_rst_status");
    chk(3'd1, 32'd50000, 1'b0, "post_rst_prescale");
    chk(3'd2, 32'd0, 1'b0, "post_rst_frozen");

    @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
